activity_monitor: RTL

Parametrised activity detector for the player-button front end. It watches `CHANNELS` asynchronous button lines and emits a one-cycle `activity` pulse on each qualifying edge, plus a configurable boot pulse after reset. It also reports which channel fired and raises a registered `idle` flag after a programmable quiet period. It sits between the raw button pins and the game/LED-refresh logic, which uses `activity` to trigger redraws and `idle` to enter attract mode.

---
 rtl/activity_monitor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/activity_monitor.sv
// activity_monitor: synchronised per-channel edge detector with boot pulse, last-channel report and idle timer.
// Optional per-channel debounce stage is compiled in when ACTIVITY_MONITOR_DEBOUNCE_EN is defined.
module activity_monitor #(
  parameter int unsigned CHANNELS          = 6,
  parameter int unsigned EDGE_MODE         = 0,
  parameter int unsigned BOOT_PULSE_CYCLES = 1,
  parameter int unsigned IDLE_CYCLES       = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES   = 4
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic [CHANNELS-1:0]                               s,
  output logic [CHANNELS-1:0]                               ch_pulse,
  output logic                                              boot,
  output logic                                              activity,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] last_ch,
  output logic                                              idle
);

  localparam int unsigned LW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BW = (BOOT_PULSE_CYCLES > 0) ? $clog2(BOOT_PULSE_CYCLES + 1) : 1;
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("activity_monitor: CHANNELS must be 1..32");
  end
  if (EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("activity_monitor: EDGE_MODE must be 0, 1 or 2");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("activity_monitor: IDLE_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("activity_monitor: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] q_w;
  logic [CHANNELS-1:0] p_q;
  logic [CHANNELS-1:0] edge_w;
  logic [CHANNELS-1:0] ch_pulse_q;
  logic [LW-1:0]       last_ch_q;
  logic [LW-1:0]       last_ch_d;
  logic [BW-1:0]       boot_cnt_q;
  logic [BW-1:0]       boot_cnt_d;
  logic                boot_q;
  logic                boot_d;
  logic [IW-1:0]       idle_cnt_q;
  logic [IW-1:0]       idle_cnt_d;
  logic                idle_q;
  logic                idle_d;
  logic                activity_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= s;
      sync2_q <= sync1_q;
    end
  end

`ifdef ACTIVITY_MONITOR_DEBOUNCE_EN
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CHANNELS-1:0] q_q;
  logic [CHANNELS-1:0] q_d;
  logic [DW-1:0]       db_cnt_q [CHANNELS];
  logic [DW-1:0]       db_cnt_d [CHANNELS];

  // q only follows sync2 after DEBOUNCE_CYCLES consecutive mismatching samples
  always_comb begin
    q_d = q_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != q_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          q_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      q_q <= q_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign q_w = q_q;
`else
  assign q_w = sync2_q;
`endif

  always_comb begin
    if (EDGE_MODE == 1) begin
      edge_w = ~q_w & p_q;
    end else if (EDGE_MODE == 2) begin
      edge_w = q_w ^ p_q;
    end else begin
      edge_w = q_w & ~p_q;
    end
  end

  // Scanning downwards leaves the lowest set index as the final assignment
  always_comb begin
    last_ch_d = last_ch_q;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (edge_w[i-1]) begin
        last_ch_d = LW'(i - 1);
      end
    end
  end

  always_comb begin
    boot_cnt_d = boot_cnt_q;
    boot_d     = 1'b0;
    if (boot_cnt_q != '0) begin
      boot_cnt_d = boot_cnt_q - BW'(1);
      boot_d     = 1'b1;
    end
  end

  assign activity_w = (|ch_pulse_q) | boot_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    idle_d     = idle_q;
    if (activity_w) begin
      idle_cnt_d = '0;
      idle_d     = 1'b0;
    end else if (idle_cnt_q != IW'(IDLE_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
      if (idle_cnt_d == IW'(IDLE_CYCLES)) begin
        idle_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q        <= '0;
      ch_pulse_q <= '0;
      last_ch_q  <= '0;
      boot_cnt_q <= BW'(BOOT_PULSE_CYCLES);
      boot_q     <= 1'b0;
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else begin
      p_q        <= q_w;
      ch_pulse_q <= edge_w;
      last_ch_q  <= last_ch_d;
      boot_cnt_q <= boot_cnt_d;
      boot_q     <= boot_d;
      idle_cnt_q <= idle_cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign ch_pulse = ch_pulse_q;
  assign boot     = boot_q;
  assign activity = activity_w;
  assign last_ch  = last_ch_q;
  assign idle     = idle_q;

endmodule
